// File: rtl/mem_map_pkg.sv
// Memory map shared by the bus arbiter: region decode constants, arbiter
// state encoding and the per-region wait-state lookup.
package mem_map_pkg;

  localparam logic [31:0] SRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK  = 32'hf000_0000;
  localparam logic [31:0] TEXT_BASE  = 32'hb000_0000;
  localparam logic [31:0] TEXT_MASK  = 32'hffff_0000;
  localparam logic [31:0] GRAPH_BASE = 32'ha000_0000;
  localparam logic [31:0] GRAPH_MASK = 32'hff00_0000;
  localparam logic [31:0] VGA_REG    = 32'hb001_0000;
  localparam logic [31:0] CURSOR_REG = 32'hb001_0004;
  localparam logic [31:0] SEG_BASE   = 32'he000_0000;
  localparam logic [31:0] SEG_MASK   = 32'hf000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  // Regions are tested in priority order so overlapping decodes resolve to the first hit.
  function automatic logic [3:0] region_ws(
    input logic [31:0] addr,
    input logic [3:0]  ws_sram,
    input logic [3:0]  ws_vram,
    input logic [3:0]  ws_io,
    input logic [3:0]  ws_other
  );
    logic [3:0] ws;
    if ((addr & SRAM_MASK) == SRAM_BASE) begin
      ws = ws_sram;
    end else if (((addr & TEXT_MASK) == TEXT_BASE) || ((addr & GRAPH_MASK) == GRAPH_BASE)) begin
      ws = ws_vram;
    end else if ((addr == VGA_REG) || (addr == CURSOR_REG) || ((addr & SEG_MASK) == SEG_BASE)) begin
      ws = ws_io;
    end else begin
      ws = ws_other;
    end
    return ws;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Two-master request/ack handshake plus the shared downstream bus.
// The slave modport is the arbiter's view; master is the requester/slave-model side.
interface mem_bus_arbiter_if;

  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_rdata;
  logic        m1_ack;

  logic        bus_cs;
  logic        bus_we;
  logic        bus_last;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [1:0]  grant;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_addr, bus_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output bus_cs, bus_we, bus_last, bus_addr, bus_wdata, grant
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_addr, bus_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  bus_cs, bus_we, bus_last, bus_addr, bus_wdata, grant
  );

endinterface

// File: rtl/bus_ws_counter.sv
// Loadable 4-bit wait-state down-counter; o_last flags that the current
// bus cycle is the final one of the access.
module bus_ws_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_last
);

  logic [3:0] r_cnt;

  // Load on grant, otherwise count down while the access is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter with per-region wait states and an
// anti-starvation streak limit protecting the instruction-fetch master.
module mem_bus_arbiter #(
  parameter int WS_SRAM    = 1,
  parameter int WS_VRAM    = 0,
  parameter int WS_IO      = 0,
  parameter int WS_OTHER   = 3,
  parameter int MAX_STREAK = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  import mem_map_pkg::*;

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  arb_state_e    r_state;
  arb_state_e    w_next;
  logic [SW-1:0] r_streak;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_m0_rdata;
  logic [31:0]   r_m1_rdata;
  logic          r_we;
  logic [1:0]    r_grant;
  logic          w_m0_win;
  logic          w_m1_win;
  logic          w_grant;
  logic          w_last;
  logic          w_in_access;
  logic [31:0]   w_win_addr;
  logic [3:0]    w_win_ws;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Arbitration and next-state decode.
  always_comb begin
    w_next   = r_state;
    w_m0_win = 1'b0;
    w_m1_win = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.m1_req && (!bus.m0_req || (r_streak == STREAK_MAX))) begin
          w_m1_win = 1'b1;
        end else if (bus.m0_req) begin
          w_m0_win = 1'b1;
        end else begin
          w_m1_win = 1'b0;
        end
        if (w_m0_win || w_m1_win) begin
          w_next = ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
      ACCESS: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = ACCESS;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_grant     = w_m0_win | w_m1_win;
  assign w_in_access = (r_state == ACCESS);
  assign w_win_addr  = w_m1_win ? bus.m1_addr : bus.m0_addr;
  assign w_win_ws    = region_ws(w_win_addr, 4'(WS_SRAM), 4'(WS_VRAM), 4'(WS_IO), 4'(WS_OTHER));

  bus_ws_counter u_ws_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_grant),
    .i_load_val (w_win_ws),
    .i_dec      (w_in_access),
    .o_last     (w_last)
  );

  // Latch the winner's request; grant is held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_grant <= 2'b00;
    end else if (w_grant) begin
      r_addr  <= w_win_addr;
      r_wdata <= w_m1_win ? 32'd0 : bus.m0_wdata;
      r_we    <= w_m0_win & bus.m0_we;
      r_grant <= {w_m1_win, w_m0_win};
    end else if (r_state == DONE) begin
      r_grant <= 2'b00;
    end else begin
      r_grant <= r_grant;
    end
  end

  // Read data is captured only on the final cycle of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rdata <= 32'd0;
      r_m1_rdata <= 32'd0;
    end else if (w_in_access && w_last && !r_we) begin
      if (r_grant[0]) begin
        r_m0_rdata <= bus.bus_rdata;
      end else begin
        r_m0_rdata <= r_m0_rdata;
      end
      if (r_grant[1]) begin
        r_m1_rdata <= bus.bus_rdata;
      end else begin
        r_m1_rdata <= r_m1_rdata;
      end
    end else begin
      r_m0_rdata <= r_m0_rdata;
      r_m1_rdata <= r_m1_rdata;
    end
  end

  // Consecutive M0 wins while M1 waits; an idle M1 or an M1 win resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= {SW{1'b0}};
    end else if (r_state == IDLE) begin
      if (w_m1_win || !bus.m1_req) begin
        r_streak <= {SW{1'b0}};
      end else if (w_m0_win && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + SW'(1'b1);
      end else begin
        r_streak <= r_streak;
      end
    end else begin
      r_streak <= r_streak;
    end
  end

  assign bus.bus_cs    = w_in_access;
  assign bus.bus_we    = w_in_access & r_we;
  assign bus.bus_last  = w_in_access & w_last;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.grant     = r_grant;
  assign bus.m0_ack    = (r_state == DONE) & r_grant[0];
  assign bus.m1_ack    = (r_state == DONE) & r_grant[1];
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized two-master traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_bus_arbiter_if bif ();

  mem_bus_arbiter #(
    .WS_SRAM(1), .WS_VRAM(0), .WS_IO(0), .WS_OTHER(3), .MAX_STREAK(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bif.m0_req    = 1'b0;
    bif.m0_we     = 1'b0;
    bif.m0_addr   = 32'd0;
    bif.m0_wdata  = 32'd0;
    bif.m1_req    = 1'b0;
    bif.m1_addr   = 32'd0;
    bif.bus_rdata = 32'd0;
  endtask

  function automatic int exp_ws(input logic [31:0] a);
    if (a[31:28] == 4'h0) return 1;
    else if (a[31:16] == 16'hb000 || a[31:24] == 8'ha0) return 0;
    else if (a == 32'hb001_0000 || a == 32'hb001_0004 || a[31:28] == 4'he) return 0;
    else return 3;
  endfunction

  function automatic logic [31:0] gen_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: return {4'h0, r[27:0]};
      1: return {16'hb000, r[15:0]};
      2: return {8'ha0, r[23:0]};
      3: return 32'hb001_0000;
      4: return 32'hb001_0004;
      5: return {4'he, r[27:0]};
      6: return {4'h2, r[27:0]};
      7: return 32'hb001_0008;
      default: return {16'hb002, r[15:0]};
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bif.grant, bif.bus_cs, bif.bus_we, bif.bus_last, bif.m0_ack, bif.m1_ack} !== 7'd0) begin
      n_err++; $display("FAIL reset_ctl got %b want 0", {bif.grant, bif.bus_cs, bif.bus_we, bif.bus_last, bif.m0_ack, bif.m1_ack});
    end
    n_vec++;
    if ({bif.bus_addr, bif.bus_wdata, bif.m0_rdata, bif.m1_rdata} !== 128'd0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {bif.bus_addr, bif.bus_wdata, bif.m0_rdata, bif.m1_rdata});
    end
    rst_n = 1'b1;
    tick();
    // Abort an SRAM read in its second ACCESS cycle.
    bif.m0_req = 1'b1; bif.m0_addr = 32'h0000_0010; bif.bus_rdata = 32'hCAFE_F00D;
    tick();
    tick();
    n_vec++;
    if (bif.bus_cs !== 1'b1) begin n_err++; $display("FAIL rst_pre_cs got %b want 1", bif.bus_cs); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bif.grant, bif.bus_cs, bif.bus_we, bif.bus_last, bif.m0_ack, bif.m1_ack} !== 7'd0 ||
        {bif.bus_addr, bif.bus_wdata, bif.m0_rdata, bif.m1_rdata} !== 128'd0) begin
      n_err++; $display("FAIL rst_mid got cs=%b grant=%b addr=%h rd=%h want all 0", bif.bus_cs, bif.grant, bif.bus_addr, bif.m0_rdata);
    end
    bif.m0_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bif.m0_ack !== 1'b0 || bif.grant !== 2'b00 || bif.bus_cs !== 1'b0) begin
        n_err++; $display("FAIL rst_after ack=%b grant=%b cs=%b want 0,00,0", bif.m0_ack, bif.grant, bif.bus_cs);
      end
    end
  endtask

  task automatic test_sram_read();
    bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 32'h0000_0010; bif.bus_rdata = 32'hDEAD_BEEF;
    tick();
    n_vec++;
    if ({bif.bus_cs, bif.bus_last, bif.grant, bif.m0_ack} !== 5'b10010) begin
      n_err++; $display("FAIL sram_c1 cs/last/grant/ack got %b want 10010", {bif.bus_cs, bif.bus_last, bif.grant, bif.m0_ack});
    end
    tick();
    n_vec++;
    if ({bif.bus_cs, bif.bus_last, bif.bus_we} !== 3'b110 || bif.bus_addr !== 32'h0000_0010) begin
      n_err++; $display("FAIL sram_c2 cs/last/we got %b addr %h want 110 00000010", {bif.bus_cs, bif.bus_last, bif.bus_we}, bif.bus_addr);
    end
    tick();
    n_vec++;
    if (bif.bus_cs !== 1'b0 || bif.m0_ack !== 1'b1 || bif.grant !== 2'b01 || bif.m0_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL sram_done cs=%b ack=%b grant=%b rdata=%h want 0,1,01,deadbeef", bif.bus_cs, bif.m0_ack, bif.grant, bif.m0_rdata);
    end
    bif.m0_req = 1'b0;
    tick();
    n_vec++;
    if (bif.m0_ack !== 1'b0 || bif.grant !== 2'b00) begin
      n_err++; $display("FAIL sram_idle ack=%b grant=%b want 0 00", bif.m0_ack, bif.grant);
    end
  endtask

  task automatic test_io_write();
    bif.m0_req = 1'b1; bif.m0_we = 1'b1; bif.m0_addr = 32'hb001_0004; bif.m0_wdata = 32'h0000_0055;
    bif.bus_rdata = 32'h1234_5678;
    tick();
    n_vec++;
    if ({bif.bus_cs, bif.bus_we, bif.bus_last} !== 3'b111 || bif.bus_wdata !== 32'h0000_0055) begin
      n_err++; $display("FAIL io_access cs/we/last got %b wdata %h want 111 00000055", {bif.bus_cs, bif.bus_we, bif.bus_last}, bif.bus_wdata);
    end
    bif.m0_req = 1'b0; bif.m0_we = 1'b0;
    tick();
    n_vec++;
    if (bif.bus_cs !== 1'b0 || bif.m0_ack !== 1'b1 || bif.m0_rdata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL io_done cs=%b ack=%b rdata=%h want 0,1,deadbeef", bif.bus_cs, bif.m0_ack, bif.m0_rdata);
    end
    tick();
  endtask

  task automatic test_dram_read();
    logic [31:0] rd;
    rd = $urandom;
    bif.m1_req = 1'b1; bif.m1_addr = 32'h2000_0000; bif.bus_rdata = rd;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({bif.bus_cs, bif.bus_we, bif.bus_last, bif.grant, bif.m1_ack} !== {1'b1, 1'b0, (i == 3), 2'b10, 1'b0}) begin
        n_err++; $display("FAIL dram_c%0d cs/we/last/grant/ack got %b want %b", i,
                          {bif.bus_cs, bif.bus_we, bif.bus_last, bif.grant, bif.m1_ack}, {1'b1, 1'b0, (i == 3), 2'b10, 1'b0});
      end
    end
    tick();
    n_vec++;
    if (bif.m1_ack !== 1'b1 || bif.m0_ack !== 1'b0 || bif.m1_rdata !== rd || bif.bus_we !== 1'b0) begin
      n_err++; $display("FAIL dram_done ack1=%b ack0=%b rdata=%h want 1,0,%h", bif.m1_ack, bif.m0_ack, bif.m1_rdata, rd);
    end
    bif.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int   k;
    logic prev_cs;
    bif.m0_req = 1'b1; bif.m0_addr = 32'hb000_0040; bif.m1_req = 1'b1; bif.m1_addr = 32'he000_0000;
    k = 0;
    prev_cs = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bif.bus_cs === 1'b1 && prev_cs !== 1'b1) begin
        n_vec++;
        if (bif.grant !== ((k % 5 == 4) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL contend_grant%0d got %b want %b", k, bif.grant, ((k % 5 == 4) ? 2'b10 : 2'b01));
        end
        k++;
      end
      n_vec++;
      if (bif.m0_ack === 1'b1 && bif.m1_ack === 1'b1) begin
        n_err++; $display("FAIL contend_acks both high at cycle %0d want at most one", c);
      end
      prev_cs = bif.bus_cs;
    end
    n_vec++;
    if (k !== 10) begin n_err++; $display("FAIL contend_count got %0d grants want 10", k); end
    bif.m0_req = 1'b0; bif.m1_req = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (bif.grant !== 2'b00) begin n_err++; $display("FAIL contend_idle grant=%b want 00", bif.grant); end
  endtask

  task automatic test_simultaneous();
    bif.m0_req = 1'b1; bif.m0_we = 1'b0; bif.m0_addr = 32'h0000_0020;
    bif.m1_req = 1'b1; bif.m1_addr = 32'hb001_0000;
    tick();
    n_vec++;
    if (bif.grant !== 2'b01) begin n_err++; $display("FAIL simul_first grant=%b want 01", bif.grant); end
    tick();
    tick();
    n_vec++;
    if (bif.m0_ack !== 1'b1 || bif.m1_ack !== 1'b0) begin
      n_err++; $display("FAIL simul_m0done ack0=%b ack1=%b want 1 0", bif.m0_ack, bif.m1_ack);
    end
    bif.m0_req = 1'b0;
    tick();
    n_vec++;
    if (bif.grant !== 2'b00 || bif.bus_cs !== 1'b0) begin
      n_err++; $display("FAIL simul_bubble grant=%b cs=%b want 00 0", bif.grant, bif.bus_cs);
    end
    tick();
    n_vec++;
    if (bif.grant !== 2'b10 || bif.bus_cs !== 1'b1 || bif.bus_last !== 1'b1) begin
      n_err++; $display("FAIL simul_m1 grant=%b cs=%b last=%b want 10 1 1", bif.grant, bif.bus_cs, bif.bus_last);
    end
    bif.m1_req = 1'b0;
    tick();
    n_vec++;
    if (bif.m1_ack !== 1'b1 || bif.m0_ack !== 1'b0) begin
      n_err++; $display("FAIL simul_m1done ack1=%b ack0=%b want 1 0", bif.m1_ack, bif.m0_ack);
    end
    tick();
  endtask

  task automatic test_random(input int n_cycles);
    logic        req [2];
    logic [31:0] addr [2];
    logic        we0;
    logic [31:0] wd0;
    logic [31:0] exp_rd [2];
    logic [31:0] cur_rd;
    logic [31:0] pend_rd;
    logic        pend_v;
    logic        busy;
    int          t_start;
    int          t_ws;
    int          owner;
    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wd;
    int          streak;
    logic        e_cs;
    logic        e_last;
    logic        e_done;
    logic [1:0]  e_grant;

    rst_n = 1'b0;
    drive_idle();
    tick();
    rst_n = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0; addr[0] = 32'd0; addr[1] = 32'd0; we0 = 1'b0; wd0 = 32'd0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; pend_rd = 32'd0; pend_v = 1'b0;
    busy = 1'b0; t_start = 0; t_ws = 0; owner = 0; t_we = 1'b0; t_addr = 32'd0; t_wd = 32'd0; streak = 0;

    for (int c = 0; c < n_cycles; c++) begin
      tick();
      e_done = busy && (c == t_start + t_ws + 1);
      if (e_done && pend_v) begin
        exp_rd[owner] = pend_rd;
        pend_v = 1'b0;
      end
      e_cs    = busy && (c <= t_start + t_ws);
      e_last  = e_cs && (c == t_start + t_ws);
      e_grant = busy ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;

      n_vec++;
      if (bif.grant !== e_grant || bif.bus_cs !== e_cs || bif.bus_last !== e_last || bif.bus_we !== (e_cs & t_we)) begin
        n_err++; $display("FAIL rand_ctl cyc %0d grant/cs/last/we got %b%b%b%b want %b%b%b%b", c,
                          bif.grant, bif.bus_cs, bif.bus_last, bif.bus_we, e_grant, e_cs, e_last, e_cs & t_we);
      end
      n_vec++;
      if (bif.m0_ack !== (e_done && owner == 0) || bif.m1_ack !== (e_done && owner == 1)) begin
        n_err++; $display("FAIL rand_ack cyc %0d ack0/ack1 got %b%b want %b%b", c, bif.m0_ack, bif.m1_ack,
                          (e_done && owner == 0), (e_done && owner == 1));
      end
      n_vec++;
      if (bif.m0_rdata !== exp_rd[0] || bif.m1_rdata !== exp_rd[1]) begin
        n_err++; $display("FAIL rand_rdata cyc %0d got %h/%h want %h/%h", c, bif.m0_rdata, bif.m1_rdata, exp_rd[0], exp_rd[1]);
      end
      if (e_cs) begin
        n_vec++;
        if (bif.bus_addr !== t_addr || (t_we && bif.bus_wdata !== t_wd)) begin
          n_err++; $display("FAIL rand_bus cyc %0d addr %h wdata %h want %h %h", c, bif.bus_addr, bif.bus_wdata, t_addr, t_wd);
        end
      end

      // Masters hold until their ack, then either chain a new access or drop.
      for (int k = 0; k < 2; k++) begin
        if ((e_done && owner == k && $urandom_range(0, 1) == 1) || (!req[k] && $urandom_range(0, 2) == 0)) begin
          req[k]  = 1'b1;
          addr[k] = gen_addr();
          if (k == 0) begin
            we0 = 1'($urandom_range(0, 1));
            wd0 = $urandom;
          end
        end else if (e_done && owner == k) begin
          req[k] = 1'b0;
        end
      end
      cur_rd = $urandom;
      bif.m0_req = req[0]; bif.m0_addr = addr[0]; bif.m0_we = we0; bif.m0_wdata = wd0;
      bif.m1_req = req[1]; bif.m1_addr = addr[1]; bif.bus_rdata = cur_rd;

      if (e_last && !t_we) begin
        pend_rd = cur_rd;
        pend_v  = 1'b1;
      end
      if (e_done) begin
        busy = 1'b0;
      end else if (!busy) begin
        owner = -1;
        if (req[1] && (!req[0] || streak == 4)) begin
          owner  = 1;
          streak = 0;
        end else if (req[0]) begin
          owner  = 0;
          streak = req[1] ? ((streak < 4) ? streak + 1 : 4) : 0;
        end else begin
          streak = 0;
        end
        if (owner >= 0) begin
          busy    = 1'b1;
          t_start = c + 1;
          t_addr  = addr[owner];
          t_ws    = exp_ws(t_addr);
          t_we    = (owner == 0) ? we0 : 1'b0;
          t_wd    = wd0;
        end else begin
          owner = 0;
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sram_read();
    test_io_write();
    test_dram_read();
    test_contention();
    test_simultaneous();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
